// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the KGP-RISC core: walks each instruction
// through FETCH/DECODE/EXEC/[MEM]/WB and emits the one-cycle datapath enables.
module instr_sequencer #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             stop,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             wr_req,
    input  logic             is_halt,
    output logic             ir_load,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_ILLEGAL = 3'd7
    } state_e;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY - 1);

    state_e           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             step_mode_q, step_mode_d;
    logic             stop_pend_q, stop_pend_d;
    logic             store_q, store_d;
    logic             wb_we_q, wb_we_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            step_mode_q <= 1'b0;
            stop_pend_q <= 1'b0;
            store_q     <= 1'b0;
            wb_we_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            step_mode_q <= step_mode_d;
            stop_pend_q <= stop_pend_d;
            store_q     <= store_d;
            wb_we_q     <= wb_we_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        step_mode_d = step_mode_q;
        stop_pend_d = stop_pend_q;
        store_d     = store_q;
        wb_we_d     = wb_we_q;
        count_d     = count_q;

        // stop is remembered in every busy state so the current instruction finishes
        if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM} && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                wcnt_d = '0;
                if (step) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (run) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (wcnt_q == LAST_WAIT) begin
                    wcnt_d  = '0;
                    state_d = S_DECODE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                state_d = is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // Capture the memory/writeback decision so outputs depend on registers only
                store_d = is_store;
                wb_we_d = wr_req & ~is_store;
                wcnt_d  = '0;
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (store_q || wcnt_q == LAST_WAIT) begin
                    wcnt_d  = '0;
                    state_d = S_WB;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_WB: begin
                count_d = count_q + CNT_W'(1);
                if (step_mode_q || stop_pend_q || stop) begin
                    state_d     = S_IDLE;
                    step_mode_d = 1'b0;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d     = S_IDLE;
                wcnt_d      = '0;
                step_mode_d = 1'b0;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        ir_load     = (state_q == S_FETCH) && (wcnt_q == LAST_WAIT);
        mem_re      = (state_q == S_MEM) && !store_q;
        mem_we      = (state_q == S_MEM) && store_q;
        reg_we      = (state_q == S_WB) && wb_we_q;
        pc_en       = (state_q == S_WB);
        busy        = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
        halted      = (state_q == S_HALT);
        state       = state_q;
        instr_count = count_q;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the KGP-RISC core.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Waits out instruction/data BRAM read latency before moving on.
- Emits the one-cycle enables (IR load, register write, memory write, PC update) that the single-cycle datapath lacks.
- Sits between the opcode controller and the datapath/PC. Provides run, single-step, stop and halt control, plus a retired-instruction counter.

Parameters:
- MEM_LATENCY, 2: BRAM read latency in cycles; legal range 1..15.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- run, input, 1: start free-running execution from IDLE.
- step, input, 1: execute exactly one instruction from IDLE.
- stop, input, 1: finish the current instruction, then return to IDLE.
- is_load, input, 1: decoded instruction reads data memory.
- is_store, input, 1: decoded instruction writes data memory.
- wr_req, input, 1: decoded instruction writes the register file.
- is_halt, input, 1: decoded instruction is a halt.
- ir_load, output, 1: latch instruction register.
- mem_re, output, 1: data-memory read enable.
- mem_we, output, 1: data-memory write enable.
- reg_we, output, 1: register-file write enable.
- pc_en, output, 1: advance PC; the branch logic chooses the target.
- busy, output, 1: FSM is not in IDLE or HALT.
- halted, output, 1: FSM is in HALT.
- state, output, 3: current state encoding, for debug.
- instr_count, output, CNT_W: count of retired instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and recovers to IDLE on the next edge.
- Reset, at any time including mid-instruction:
  - state=IDLE; instr_count=0.
  - ir_load, mem_re, mem_we, reg_we, pc_en, busy, halted all 0.
  - step_mode and stop_pending flags cleared.
  - No pending strobe survives reset.
- Output decoding: all outputs are decoded from registered state only (state, wait counter, flags). is_* and wr_req are sampled only in DECODE, EXEC and MEM, while the IR is stable.
- IDLE:
  - step=1 → FETCH with step_mode=1. If step and run are high together, step wins.
  - Otherwise run=1 → FETCH with step_mode=0.
  - Otherwise stay in IDLE.
- FETCH:
  - Stays MEM_LATENCY cycles, tracked by a 4-bit wait counter.
  - ir_load=1 only in the last FETCH cycle.
  - Then → DECODE.
- DECODE: one cycle. is_halt=1 → HALT; else → EXEC.
- EXEC: one cycle. is_load or is_store → MEM; else → WB.
- MEM:
  - Load: mem_re=1 for MEM_LATENCY cycles, then → WB.
  - Store: mem_we=1 for exactly one cycle, MEM lasts one cycle, then → WB.
  - If is_load and is_store are both set, treat as a store.
- WB: one cycle.
  - reg_we = wr_req & ~is_store.
  - pc_en=1.
  - instr_count increments by 1, wrapping from all-ones to 0.
  - Next state: if step_mode or stop_pending or stop → IDLE, clearing both flags; else → FETCH.
- stop outside IDLE and HALT sets stop_pending. The current instruction always completes.
- run or step while busy is ignored.
- HALT:
  - halted=1; no strobes; PC is not advanced; the halt instruction is not counted.
  - Exit only via reset. run, step and stop are ignored.
- busy=1 in FETCH through WB.
- Latency at MEM_LATENCY=2:
  - ALU/branch instruction: 5 cycles (FETCH 2, DECODE, EXEC, WB).
  - Load: 7 cycles.
  - Store: 6 cycles.
  - Halt: DECODE → HALT after 3 cycles.
- Every enable is high for at most one cycle per instruction, except mem_re, which is held MEM_LATENCY cycles.

Test Plan:
- Reset, then run=1 for 1 cycle with an ALU instruction (wr_req=1), MEM_LATENCY=2:
  - ir_load in cycle 2; reg_we and pc_en together in cycle 5.
  - instr_count=1; next FETCH starts in cycle 6.
- Load (is_load=1, wr_req=1): mem_re high for exactly 2 cycles; reg_we and pc_en in cycle 7. Store (is_store=1, wr_req=1): mem_we high for 1 cycle; reg_we stays 0; pc_en in cycle 6.
- step and run pulsed in the same IDLE cycle:
  - Exactly one instruction retires, then IDLE with busy=0 and instr_count=1.
  - A second step retires one more: instr_count=2.
- stop pulsed during FETCH of instruction 3 while running: instruction 3 completes (instr_count=3) and the FSM returns to IDLE.
- is_halt=1 at DECODE:
  - HALT reached; halted=1; no pc_en; instr_count unchanged.
  - run and step are then ignored for 10 cycles.
  - reset clears halted to 0.
- Assert reset in MEM of a load while mem_re=1: all outputs 0 immediately (asynchronously) and state=0. Separately, with instr_count forced to 0xFFFFFFFF, one WB wraps it to 0.
